// File: rtl/ram_bist_if.sv
// ram_bist_if: single-port RAM port bundle (word addr, cen/wen, 16-bit data).
// master = BIST/controller side, slave = RAM side.
interface ram_bist_if #(
   parameter int ADDR_MSB = 6
);
   logic [ADDR_MSB:0] ram_addr;
   logic              ram_cen;
   logic [1:0]        ram_wen;
   logic [15:0]       ram_din;
   logic [15:0]       ram_dout;

   modport master (
      output ram_addr,
      output ram_cen,
      output ram_wen,
      output ram_din,
      input  ram_dout
   );

   modport slave (
      input  ram_addr,
      input  ram_cen,
      input  ram_wen,
      input  ram_din,
      output ram_dout
   );
endinterface

// File: rtl/ram_bist.sv
// ram_bist: March C- self-test controller for a single-port 16-bit RAM.
// Ports: mclk/puc_rst clock + sync reset; bist_start/busy/done/pass and
// bist_fail_addr/data/elem status; ram (master) drives addr/cen/wen/din
// and samples dout one cycle after each read.
module ram_bist #(
   parameter int ADDR_MSB = 6,
   parameter int MEM_SIZE = 256
) (
   input  logic              mclk,
   input  logic              puc_rst,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_pass,
   output logic [ADDR_MSB:0] bist_fail_addr,
   output logic [15:0]       bist_fail_data,
   output logic [2:0]        bist_fail_elem,
   ram_bist_if.master        ram
);
   localparam int AW = ADDR_MSB + 1;
   localparam int N  = MEM_SIZE / 2;
   localparam logic [ADDR_MSB:0] LAST = AW'(N - 1);
   localparam logic [ADDR_MSB:0] ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_CHK,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [2:0]        elem_q;
   logic              wr_ph_q;
   logic [ADDR_MSB:0] addr_q;
   logic              cen_q;
   logic [1:0]        wen_q;
   logic [15:0]       din_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [ADDR_MSB:0] faddr_q;
   logic [15:0]       fdata_q;
   logic [2:0]        felem_q;

   logic [15:0]       exp_rd;
   logic [15:0]       wr_val;
   logic              desc;
   logic              last_a;
   logic              is_e0;
   logic              is_e5;
   logic              cmp_en;
   logic              mism;
   logic [ADDR_MSB:0] step_a;
   logic [ADDR_MSB:0] cmp_addr;

   always_comb begin
      exp_rd   = (elem_q == 3'd2 || elem_q == 3'd4) ? 16'hFFFF : 16'h0000;
      wr_val   = (elem_q == 3'd1 || elem_q == 3'd3) ? 16'hFFFF : 16'h0000;
      desc     = (elem_q == 3'd3 || elem_q == 3'd4);
      last_a   = desc ? (addr_q == '0) : (addr_q == LAST);
      step_a   = desc ? addr_q - ONE : addr_q + ONE;
      is_e0    = (elem_q == 3'd0);
      is_e5    = (elem_q == 3'd5);
      cmp_en   = 1'b0;
      cmp_addr = addr_q;
      if (state_q == S_RUN) begin
         if (is_e5) begin
            // E5 reads are checked one address late
            cmp_en   = (addr_q != '0);
            cmp_addr = addr_q - ONE;
         end else if (!is_e0) begin
            cmp_en = wr_ph_q;
         end
      end else if (state_q == S_CHK) begin
         // last E5 read lands here, RAM already idle
         cmp_en   = 1'b1;
         cmp_addr = LAST;
      end
      mism = cmp_en && (ram.ram_dout != exp_rd);
   end

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state_q <= S_IDLE;
         elem_q  <= '0;
         wr_ph_q <= 1'b0;
         addr_q  <= '0;
         cen_q   <= 1'b1;
         wen_q   <= 2'b11;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         faddr_q <= '0;
         fdata_q <= '0;
         felem_q <= '0;
      end else if (mism) begin
         state_q <= S_DONE;
         busy_q  <= 1'b0;
         done_q  <= 1'b1;
         pass_q  <= 1'b0;
         faddr_q <= cmp_addr;
         fdata_q <= ram.ram_dout;
         felem_q <= elem_q;
         addr_q  <= '0;
         cen_q   <= 1'b1;
         wen_q   <= 2'b11;
         din_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (bist_start) begin
                  state_q <= S_RUN;
                  elem_q  <= '0;
                  wr_ph_q <= 1'b0;
                  addr_q  <= '0;
                  cen_q   <= 1'b0;
                  wen_q   <= 2'b00;
                  din_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  faddr_q <= '0;
                  fdata_q <= '0;
                  felem_q <= '0;
               end
            end
            S_RUN: begin
               unique case (1'b1)
                  is_e0: begin
                     if (last_a) begin
                        elem_q <= 3'd1;
                        addr_q <= '0;
                        wen_q  <= 2'b11;
                        din_q  <= '0;
                     end else begin
                        addr_q <= step_a;
                     end
                  end
                  is_e5: begin
                     if (last_a) begin
                        state_q <= S_CHK;
                        addr_q  <= '0;
                        cen_q   <= 1'b1;
                     end else begin
                        addr_q <= step_a;
                     end
                  end
                  (!is_e0 && !is_e5 && !wr_ph_q): begin
                     wr_ph_q <= 1'b1;
                     wen_q   <= 2'b00;
                     din_q   <= wr_val;
                  end
                  (!is_e0 && !is_e5 && wr_ph_q): begin
                     wr_ph_q <= 1'b0;
                     wen_q   <= 2'b11;
                     din_q   <= '0;
                     if (last_a) begin
                        elem_q <= elem_q + 3'd1;
                        // E3/E4 run descending from the top word
                        addr_q <= (elem_q == 3'd2 || elem_q == 3'd3)
                                  ? LAST : '0;
                     end else begin
                        addr_q <= step_a;
                     end
                  end
               endcase
            end
            S_CHK: begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bist_busy      = busy_q;
   assign bist_done      = done_q;
   assign bist_pass      = pass_q;
   assign bist_fail_addr = faddr_q;
   assign bist_fail_data = fdata_q;
   assign bist_fail_elem = felem_q;
   assign ram.ram_addr   = addr_q;
   assign ram.ram_cen    = cen_q;
   assign ram.ram_wen    = wen_q;
   assign ram.ram_din    = din_q;
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: scoreboard bench for ram_bist, N=128 and N=8 instances
// driving behavioural RAMs with injectable read faults.
module tb_ram_bist;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, st0, st1;
   logic busy0, done0, pass0, busy1, done1, pass1;
   logic [6:0]  fa0;
   logic [2:0]  fa1;
   logic [15:0] fd0, fd1;
   logic [2:0]  fe0, fe1;

   ram_bist_if #(.ADDR_MSB(6)) rif0 ();
   ram_bist_if #(.ADDR_MSB(2)) rif1 ();

   ram_bist #(.ADDR_MSB(6), .MEM_SIZE(256)) dut0 (
      .mclk(clk), .puc_rst(rst0), .bist_start(st0),
      .bist_busy(busy0), .bist_done(done0), .bist_pass(pass0),
      .bist_fail_addr(fa0), .bist_fail_data(fd0),
      .bist_fail_elem(fe0), .ram(rif0)
   );

   ram_bist #(.ADDR_MSB(2), .MEM_SIZE(16)) dut1 (
      .mclk(clk), .puc_rst(rst1), .bist_start(st1),
      .bist_busy(busy1), .bist_done(done1), .bist_pass(pass1),
      .bist_fail_addr(fa1), .bist_fail_data(fd1),
      .bist_fail_elem(fe1), .ram(rif1)
   );

   // behavioural RAMs; fault overlay corrupts read data only
   logic        flt_en [2];
   int          flt_a  [2];
   logic [15:0] flt_m  [2];
   logic [15:0] flt_v  [2];
   logic [15:0] mem0 [128];
   logic [15:0] mem1 [8];

   function automatic logic [15:0] ovl(int d, int a, logic [15:0] v);
      if (flt_en[d] && a == flt_a[d])
         return (v & ~flt_m[d]) | (flt_v[d] & flt_m[d]);
      return v;
   endfunction

   always @(posedge clk) begin
      if (!rif0.ram_cen) begin
         if (rif0.ram_wen == 2'b11)
            rif0.ram_dout <= ovl(0, int'(rif0.ram_addr), mem0[rif0.ram_addr]);
         else begin
            if (!rif0.ram_wen[0]) mem0[rif0.ram_addr][7:0]  <= rif0.ram_din[7:0];
            if (!rif0.ram_wen[1]) mem0[rif0.ram_addr][15:8] <= rif0.ram_din[15:8];
         end
      end
   end

   always @(posedge clk) begin
      if (!rif1.ram_cen) begin
         if (rif1.ram_wen == 2'b11)
            rif1.ram_dout <= ovl(1, int'(rif1.ram_addr), mem1[rif1.ram_addr]);
         else begin
            if (!rif1.ram_wen[0]) mem1[rif1.ram_addr][7:0]  <= rif1.ram_din[7:0];
            if (!rif1.ram_wen[1]) mem1[rif1.ram_addr][15:8] <= rif1.ram_din[15:8];
         end
      end
   end

   typedef struct {
      int          d;
      logic        pass;
      logic [6:0]  addr;
      logic [15:0] data;
      logic [2:0]  elem;
      int          cyc;
   } res_t;

   typedef struct {
      int          cyc;
      logic [6:0]  addr;
      logic [1:0]  wen;
      logic [15:0] din;
   } acc_t;

   res_t exp_q[$];
   acc_t acc_q[$];
   int   checks = 0;
   int   errors = 0;
   int   bcnt[2];
   int   nres[2];
   int   idle_err[2];
   logic bz_p[2];
   logic dn_p[2];
   logic mon_on = 1'b0;

   logic        bz[2], dn[2], ps[2], cn[2];
   logic [6:0]  fa[2];
   logic [15:0] fd[2];
   logic [2:0]  fe[2];

   always_comb begin
      bz[0] = busy0; dn[0] = done0; ps[0] = pass0; cn[0] = rif0.ram_cen;
      fa[0] = fa0;   fd[0] = fd0;   fe[0] = fe0;
      bz[1] = busy1; dn[1] = done1; ps[1] = pass1; cn[1] = rif1.ram_cen;
      fa[1] = {4'b0, fa1}; fd[1] = fd1; fe[1] = fe1;
   end

   // monitor: busy-cycle counting, result and access scoreboards
   always @(negedge clk) begin
      if (mon_on) begin
         for (int d = 0; d < 2; d++) begin
            if (bz[d]) bcnt[d] = bz_p[d] ? bcnt[d] + 1 : 1;
            if (!bz[d] && !cn[d]) idle_err[d]++;
            if (dn[d] && !dn_p[d]) begin
               res_t e;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL result_unexpected dut%0d", d);
               end else begin
                  e = exp_q.pop_front();
                  if (e.d != d || e.pass != ps[d] || e.addr != fa[d] ||
                      e.data != fd[d] || e.elem != fe[d] || e.cyc != bcnt[d]) begin
                     errors++;
                     $display("FAIL result dut%0d: got pass=%0b addr=%0d data=%h elem=%0d busy=%0d want dut%0d pass=%0b addr=%0d data=%h elem=%0d busy=%0d",
                        d, ps[d], fa[d], fd[d], fe[d], bcnt[d],
                        e.d, e.pass, e.addr, e.data, e.elem, e.cyc);
                  end
               end
               nres[d]++;
            end
            bz_p[d] = bz[d];
            dn_p[d] = dn[d];
         end
         if (busy0 && acc_q.size() > 0 && acc_q[0].cyc == bcnt[0]) begin
            acc_t a;
            a = acc_q.pop_front();
            checks++;
            if (rif0.ram_cen !== 1'b0 || rif0.ram_addr !== a.addr ||
                rif0.ram_wen !== a.wen ||
                (a.wen == 2'b00 && rif0.ram_din !== a.din)) begin
               errors++;
               $display("FAIL access cyc%0d: got cen=%0b addr=%0d wen=%b din=%h want cen=0 addr=%0d wen=%b din=%h",
                  a.cyc, rif0.ram_cen, rif0.ram_addr, rif0.ram_wen,
                  rif0.ram_din, a.addr, a.wen, a.din);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic pulse(int d);
      if (d == 0) st0 = 1'b1; else st1 = 1'b1;
      tick();
      if (d == 0) st0 = 1'b0; else st1 = 1'b0;
   endtask

   task automatic exp_res(int d, logic p, int a, logic [15:0] dat,
                          int el, int cyc);
      res_t r;
      r.d = d; r.pass = p; r.addr = 7'(a); r.data = dat;
      r.elem = 3'(el); r.cyc = cyc;
      exp_q.push_back(r);
   endtask

   task automatic exp_acc(int cyc, int a, logic [1:0] w, logic [15:0] v);
      acc_t x;
      x.cyc = cyc; x.addr = 7'(a); x.wen = w; x.din = v;
      acc_q.push_back(x);
   endtask

   task automatic wait_res(int d, int n, int maxc);
      int c = 0;
      while (nres[d] < n && c < maxc) begin
         tick();
         c++;
      end
      checks++;
      if (nres[d] < n) begin
         errors++;
         $display("FAIL timeout dut%0d: results %0d want %0d", d, nres[d], n);
      end
   endtask

   task automatic wait_cyc(int d, int n);
      int c = 0;
      while (bcnt[d] != n && c < 2000) begin
         tick();
         c++;
      end
      checks++;
      if (bcnt[d] != n) begin
         errors++;
         $display("FAIL wait_cyc dut%0d: at %0d want %0d", d, bcnt[d], n);
      end
   endtask

   task automatic set_flt(int d, logic en, int a, logic [15:0] m,
                          logic [15:0] v);
      flt_en[d] = en; flt_a[d] = a; flt_m[d] = m; flt_v[d] = v;
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; st0 = 1'b0; st1 = 1'b0;
      for (int d = 0; d < 2; d++) begin
         set_flt(d, 1'b0, 0, 16'h0, 16'h0);
         bcnt[d] = 0; nres[d] = 0; idle_err[d] = 0;
         bz_p[d] = 1'b0; dn_p[d] = 1'b0;
      end
      repeat (3) tick();
      rst0 = 1'b0; rst1 = 1'b0;
      tick();
      chk("reset0", {busy0, done0, pass0, fa0, fd0, fe0, rif0.ram_cen,
                     rif0.ram_wen, rif0.ram_addr, rif0.ram_din},
          {3'b000, 7'd0, 16'd0, 3'd0, 1'b1, 2'b11, 7'd0, 16'd0});
      chk("reset1", {busy1, done1, pass1, fa1, fd1, fe1, rif1.ram_cen,
                     rif1.ram_wen, rif1.ram_addr, rif1.ram_din},
          {3'b000, 3'd0, 16'd0, 3'd0, 1'b1, 2'b11, 3'd0, 16'd0});
      mon_on = 1'b1;

      // clean N=128 run with access-sequence spot checks
      exp_acc(1,    0,   2'b00, 16'h0000);
      exp_acc(2,    1,   2'b00, 16'h0000);
      exp_acc(128,  127, 2'b00, 16'h0000);
      exp_acc(129,  0,   2'b11, 16'h0000);
      exp_acc(130,  0,   2'b00, 16'hFFFF);
      exp_acc(385,  0,   2'b11, 16'h0000);
      exp_acc(386,  0,   2'b00, 16'h0000);
      exp_acc(641,  127, 2'b11, 16'h0000);
      exp_acc(642,  127, 2'b00, 16'hFFFF);
      exp_acc(897,  127, 2'b11, 16'h0000);
      exp_acc(1153, 0,   2'b11, 16'h0000);
      exp_acc(1280, 127, 2'b11, 16'h0000);
      exp_res(0, 1'b1, 0, 16'h0000, 0, 1281);
      pulse(0);
      wait_res(0, 1, 1400);

      // mem[5] bit 3 stuck-at-0: caught in E2
      set_flt(0, 1'b1, 5, 16'h0008, 16'h0000);
      exp_res(0, 1'b0, 5, 16'hFFF7, 2, 396);
      pulse(0);
      wait_res(0, 2, 1400);

      // mem[127] stuck at 0x0001: caught at the end of E1
      set_flt(0, 1'b1, 127, 16'hFFFF, 16'h0001);
      exp_res(0, 1'b0, 127, 16'h0001, 1, 384);
      pulse(0);
      wait_res(0, 3, 1400);

      // corruption appearing in E5: delayed compare path
      set_flt(0, 1'b0, 0, 16'h0, 16'h0);
      exp_res(0, 1'b0, 3, 16'h0100, 5, 1157);
      pulse(0);
      wait_cyc(0, 1153);
      set_flt(0, 1'b1, 3, 16'hFFFF, 16'h0100);
      wait_res(0, 4, 400);

      // corruption of the top word: compare lands in CHK
      set_flt(0, 1'b0, 0, 16'h0, 16'h0);
      exp_res(0, 1'b0, 127, 16'h0100, 5, 1281);
      pulse(0);
      wait_cyc(0, 1153);
      set_flt(0, 1'b1, 127, 16'hFFFF, 16'h0100);
      wait_res(0, 5, 400);

      // reset mid-run, then a full clean run
      set_flt(0, 1'b0, 0, 16'h0, 16'h0);
      pulse(0);
      wait_cyc(0, 300);
      rst0 = 1'b1;
      tick();
      chk("rst_mid", {rif0.ram_cen, busy0, done0}, 3'b100);
      rst0 = 1'b0;
      tick();
      exp_res(0, 1'b1, 0, 16'h0000, 0, 1281);
      pulse(0);
      wait_res(0, 6, 1400);

      // N=8 instance: clean, then mem[7] stuck at 0xFFFF
      exp_res(1, 1'b1, 0, 16'h0000, 0, 81);
      pulse(1);
      wait_res(1, 1, 200);
      set_flt(1, 1'b1, 7, 16'hFFFF, 16'hFFFF);
      exp_res(1, 1'b0, 7, 16'hFFFF, 1, 24);
      pulse(1);
      wait_res(1, 2, 200);

      // restart from a failed DONE clears the status during the run
      set_flt(1, 1'b0, 0, 16'h0, 16'h0);
      exp_res(1, 1'b1, 0, 16'h0000, 0, 81);
      pulse(1);
      chk("restart_clr", {busy1, done1, pass1, fa1, fd1, fe1},
          {1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 3'd0});
      wait_res(1, 3, 200);

      // start held high: no mid-run restart, restart only from DONE
      exp_res(1, 1'b1, 0, 16'h0000, 0, 81);
      exp_res(1, 1'b1, 0, 16'h0000, 0, 81);
      st1 = 1'b1;
      repeat (90) tick();
      st1 = 1'b0;
      wait_res(1, 5, 300);
      repeat (10) tick();
      chk("held_single", {busy1, done1, 32'(nres[1])}, {2'b01, 32'd5});

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
      chk("idle_access0", 64'(idle_err[0]), 64'd0);
      chk("idle_access1", 64'(idle_err[1]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test controller that masters the single-port RAM interface (address, low-active chip enable, low-active byte write enables, write data, read data with one-cycle latency). It runs a March C- algorithm over every word of the attached RAM and reports pass/fail with first-failure diagnostics. It sits between the test/debug logic and the RAM, in front of the normal RAM port mux, and owns the RAM port while busy.

## Interface
Parameters:
- ADDR_MSB, 6, MSB of the RAM word address bus
- MEM_SIZE, 256, RAM size in bytes; word count N = MEM_SIZE/2, where N <= 2^(ADDR_MSB+1) and N >= 2

Ports:
- mclk  input  1  clock; single clock domain, all state on rising edge
- puc_rst  input  1  reset, synchronous, active-high
- bist_start  input  1  start request, sampled in IDLE or DONE
- bist_busy  output  1  test in progress
- bist_done  output  1  test finished; level, held until next start
- bist_pass  output  1  1 = no mismatch; valid while bist_done=1
- bist_fail_addr  output  ADDR_MSB+1  word address of first mismatch
- bist_fail_data  output  16  data read at first mismatch
- bist_fail_elem  output  3  march element (0-5) of first mismatch
- ram_addr  output  ADDR_MSB+1  RAM word address
- ram_cen  output  1  RAM chip enable, low active
- ram_wen  output  2  RAM byte write enables, low active; 2'b00 = word write, 2'b11 = read
- ram_din  output  16  RAM write data
- ram_dout  input  16  RAM read data; valid in the cycle after a cen-low access, for the address of that access

## Operation
- All ram_* outputs, bist_* outputs driven directly from flops.
- States: IDLE -> RUN -> CHK -> DONE; DONE -> RUN on bist_start; any state -> IDLE on puc_rst.
- March elements in RUN (A = ascending 0..N-1, D = descending N-1..0):
  - E0 A: w 0x0000
  - E1 A: r 0x0000, w 0xFFFF
  - E2 A: r 0xFFFF, w 0x0000
  - E3 D: r 0x0000, w 0xFFFF
  - E4 D: r 0xFFFF, w 0x0000
  - E5 A: r 0x0000
- Read/write elements: per address, read cycle (cen=0, wen=11) then write cycle (cen=0, wen=00) to the same address. ram_dout is compared against the expected value during the write cycle, i.e. before the write edge.
- Read-only elements (E5): one read cycle per address. The compare for address k happens in the cycle of address k+1. The compare for the last address happens in CHK (cen=1).
- Mismatch (ram_dout != expected): capture address, ram_dout and element into bist_fail_*, clear pass, and abort to DONE on the next edge. No further RAM access after the mismatch cycle.
- Idle RAM outputs (IDLE, DONE, CHK): ram_cen=1, ram_wen=2'b11, ram_din=0, ram_addr=0.
- bist_start while busy: ignored. bist_start in DONE: clears done/pass/fail_*, restarts at E0.

## Timing
- Reset values: bist_busy=0, bist_done=0, bist_pass=0, bist_fail_addr=0, bist_fail_data=0, bist_fail_elem=0, ram_cen=1, ram_wen=2'b11, ram_din=0, ram_addr=0.
- bist_start sampled high at edge t. From cycle t+1:
  - bist_busy=1;
  - ram_cen=0, ram_addr=0, ram_wen=00, ram_din=0x0000 (first E0 write).
- Cycle budget: E0 = N cycles, E1-E4 = 2N each, E5 = N, CHK = 1. bist_busy stays high for exactly 10N+1 cycles.
- bist_done=1 and bist_busy=0 in the same cycle, directly after CHK or after the aborting compare. bist_pass=1 in that cycle if no mismatch occurred.
- Element boundaries have no gap cycles. The descending elements start at N-1. The address counter never wraps: each element ends at its final address (N-1 ascending, 0 descending).
- puc_rst mid-test: next cycle is IDLE with reset values and ram_cen=1. A pending RAM write is not completed. puc_rst has priority over bist_start.

## Test plan
- Clean RAM, N=128 (defaults): pulse bist_start → busy exactly 1281 cycles, then done=1, pass=1, fail_* = 0. Access sequence checked: first E1 read at addr 0, first E3 access at addr 127.
- Force mem[5] bit 3 stuck-at-0 → done after E2's addr-5 compare: pass=0, fail_addr=5, fail_data=0xFFF7, fail_elem=2. No RAM access after abort.
- Force mem[127] stuck at 0x0001 (MEM_SIZE=256) → fail_elem=1, fail_addr=127, fail_data=0x0001.
- MEM_SIZE=16, ADDR_MSB=2 (N=8) → busy 81 cycles, pass=1. Then mem[7] stuck at 0xFFFF → fail_elem=1, fail_addr=7.
- bist_start held high throughout → single run, with restart only from DONE. Restart clears fail_* and pass during the new run.
- puc_rst asserted at cycle 300 of a run → next cycle ram_cen=1, busy=0, done=0. New start gives a full 1281-cycle pass.
